turbo_siso_sched: RTL and testbench
===================================

# turbo_siso_sched

Iteration scheduler for a single shared max-log-MAP SISO datapath in the turbo decoder. It sequences the forward (alpha) and backward (beta/LLR) trellis sweeps over one code block. It alternates natural and interleaved half-iterations and stops after a programmed iteration count or on an early-stop flag. It sits between the block input buffer/host handshake and the SISO core, driving the SISO's address, phase and trellis-initialisation controls.

## Interface
Parameters:
- BLOCK_LEN, 40, information bits per block (K).
- STATES, 8, trellis states; TAIL = $clog2(STATES) termination steps.
- SWEEP_LEN, BLOCK_LEN+TAIL, trellis steps per sweep (L), derived.
- ADDR_W, $clog2(SWEEP_LEN), step address width, derived.
- ITER_W, 4, width of iteration count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin decoding a block; honoured only in IDLE.
- n_iter  in  ITER_W  full iterations to run, sampled with start; 0 treated as 1.
- early_stop  in  1  SISO hard-decision convergence flag, sampled in HALF_END.
- siso_ready  in  1  SISO accepts the current step this cycle.
- siso_vld  out  1  step address valid.
- siso_addr  out  ADDR_W  trellis step index.
- siso_dir  out  1  0 = forward sweep, 1 = backward sweep.
- siso_half  out  1  0 = natural-order half, 1 = interleaved half.
- siso_init  out  1  high on the first step of each sweep: reset metrics to state 0, others to -inf.
- siso_llr_en  out  1  extrinsic write enable; high on backward steps with addr < BLOCK_LEN.
- iter_cnt  out  ITER_W  completed full iterations.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of block.

## Operation
- States: IDLE, FWD, BWD, HALF_END, DONE.
- IDLE: all outputs 0. If start=1, latch n_iter (0→1), clear iter_cnt, half=0, addr=0, and go to FWD.
- FWD: siso_vld=1, dir=0, addr counts 0..L-1.
  - addr advances only on cycles with siso_ready=1; otherwise it and all controls hold.
  - siso_init=1 while addr=0.
  - Accepting addr L-1 moves to BWD with addr=L-1.
- BWD: dir=1, addr counts L-1..0 with the same ready rule.
  - siso_init=1 while addr=L-1, for terminated-trellis beta initialisation.
  - siso_llr_en = siso_vld & (addr < BLOCK_LEN).
  - Accepting addr 0 moves to HALF_END.
- HALF_END: one cycle, siso_vld=0.
  - If half=0: set half=1 and go to FWD (addr=0).
  - If half=1: iter_cnt+1, half=0.
    - If new iter_cnt == latched n_iter, or early_stop=1, go to DONE.
    - Otherwise go to FWD.
- DONE: done=1 and busy=1 for one cycle, then IDLE. iter_cnt holds its value until the next accepted start.
- start is ignored while busy. n_iter changes after start have no effect.
- Reset mid-operation: next cycle IDLE, all outputs 0, no done pulse.
- Counter arithmetic is unsigned and never wraps. iter_cnt saturates at n_iter, which is at most 2^ITER_W-1.

## Timing
- Start to first siso_vld: 1 cycle (start sampled at edge N, FWD addr 0 visible after edge N+1).
- With siso_ready held at 1, one half-iteration takes 2L+1 cycles.
- With siso_ready held at 1, a block takes n_iter·2·(2L+1) cycles from the first FWD cycle to the last HALF_END cycle. DONE follows 1 cycle later.
- Every siso_ready=0 cycle during FWD/BWD adds exactly one cycle. siso_ready is ignored in other states.
- Outputs are registered; no combinational path from siso_ready to siso_addr.

## Test plan
- BLOCK_LEN=4, STATES=4 (L=6), n_iter=1, siso_ready=1: FWD addr 0..5 on cycles 1–6, BWD 5..0 on cycles 7–12, HALF_END on 13. Second half (siso_half=1) runs cycles 14–26. done on cycle 27, iter_cnt=1, busy low on cycle 28.
- Same configuration with siso_ready=0 on FWD addr 3 for 2 cycles: addr holds at 3 for 3 cycles, and done shifts to cycle 29.
- n_iter=0: behaves exactly like n_iter=1. n_iter=3 with no early_stop: done after 6 halves, iter_cnt=3.
- n_iter=5, early_stop=1 only in the HALF_END that ends iteration 2: done follows, iter_cnt=2. early_stop=1 at a half=0 HALF_END has no effect.
- siso_llr_en and siso_init: llr_en is high only for BWD addr 3..0. init is high at FWD addr 0 and BWD addr 5 of each half.
- reset_n=0 during BWD of iteration 1: IDLE next cycle, all outputs 0, no done pulse. A start pulse while busy is ignored, and a fresh start after reset decodes normally.

Source files
------------

// File: rtl/turbo_siso_sched.sv
`default_nettype none
// ============================================================================
// Module   : turbo_siso_sched
// Purpose  : Iteration scheduler for one shared max-log-MAP SISO datapath.
//            Runs a forward (alpha) sweep followed by a backward (beta/LLR)
//            sweep over L = BLOCK_LEN + TAIL trellis steps, alternating
//            natural and interleaved half-iterations until the programmed
//            iteration count is reached or the SISO reports convergence.
// Ports    : clk, reset_n (sync, active-low)
//            start, n_iter, early_stop, siso_ready  - host / SISO inputs
//            siso_vld, siso_addr, siso_dir, siso_half,
//            siso_init, siso_llr_en                 - SISO step controls
//            iter_cnt, busy, done                   - host status
// Revision : 1.0 - initial release
// ============================================================================
module turbo_siso_sched #(
    parameter int BLOCK_LEN = 40,
    parameter int STATES    = 8,
    parameter int SWEEP_LEN = BLOCK_LEN + $clog2(STATES),
    parameter int ADDR_W    = $clog2(SWEEP_LEN),
    parameter int ITER_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              early_stop,
    input  logic              siso_ready,
    output logic              siso_vld,
    output logic [ADDR_W-1:0] siso_addr,
    output logic              siso_dir,
    output logic              siso_half,
    output logic              siso_init,
    output logic              siso_llr_en,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(SWEEP_LEN - 1);
    localparam logic [ADDR_W-1:0] c_block_addr = ADDR_W'(BLOCK_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FWD      = 3'd1,
        S_BWD      = 3'd2,
        S_HALF_END = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_half;
    logic [ITER_W-1:0]   r_iter;
    logic [ITER_W-1:0]   r_n_iter;

    state_t              w_state;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_half;
    logic [ITER_W-1:0]   w_iter;
    logic [ITER_W-1:0]   w_n_iter;
    logic [ITER_W-1:0]   w_iter_inc;
    logic                w_vld;

    assign w_iter_inc = r_iter + ITER_W'(1);

    // Next-state of the schedule. The outputs are registered from these
    // values, so siso_ready only reaches the outputs through a flop.
    always_comb begin
        w_state  = r_state;
        w_addr   = r_addr;
        w_half   = r_half;
        w_iter   = r_iter;
        w_n_iter = r_n_iter;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_n_iter = (n_iter == '0) ? ITER_W'(1) : n_iter;
                    w_iter   = '0;
                    w_half   = 1'b0;
                    w_addr   = '0;
                    w_state  = S_FWD;
                end
            end
            S_FWD: begin
                if (siso_ready) begin
                    // The backward sweep starts on the step just accepted.
                    if (r_addr == c_last_addr) begin
                        w_state = S_BWD;
                    end else begin
                        w_addr = r_addr + ADDR_W'(1);
                    end
                end
            end
            S_BWD: begin
                if (siso_ready) begin
                    if (r_addr == '0) begin
                        w_state = S_HALF_END;
                    end else begin
                        w_addr = r_addr - ADDR_W'(1);
                    end
                end
            end
            S_HALF_END: begin
                w_addr = '0;
                if (!r_half) begin
                    w_half  = 1'b1;
                    w_state = S_FWD;
                end else begin
                    // Stopping exactly at n_iter keeps iter_cnt saturated.
                    w_iter = w_iter_inc;
                    w_half = 1'b0;
                    if ((w_iter_inc == r_n_iter) || early_stop) begin
                        w_state = S_DONE;
                    end else begin
                        w_state = S_FWD;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign w_vld = (w_state == S_FWD) || (w_state == S_BWD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_half      <= 1'b0;
            r_iter      <= '0;
            r_n_iter    <= '0;
            siso_vld    <= 1'b0;
            siso_addr   <= '0;
            siso_dir    <= 1'b0;
            siso_half   <= 1'b0;
            siso_init   <= 1'b0;
            siso_llr_en <= 1'b0;
            iter_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_half      <= w_half;
            r_iter      <= w_iter;
            r_n_iter    <= w_n_iter;
            siso_vld    <= w_vld;
            siso_addr   <= w_vld ? w_addr : '0;
            siso_dir    <= (w_state == S_BWD);
            siso_half   <= (w_vld || (w_state == S_HALF_END)) ? w_half : 1'b0;
            // Forward metrics start from step 0; the terminated trellis
            // lets beta start from state 0 at the last step.
            siso_init   <= ((w_state == S_FWD) && (w_addr == '0)) ||
                           ((w_state == S_BWD) && (w_addr == c_last_addr));
            // Tail steps carry no information bits, so no extrinsic write.
            siso_llr_en <= (w_state == S_BWD) && (w_addr < c_block_addr);
            iter_cnt    <= w_iter;
            busy        <= (w_state != S_IDLE);
            done        <= (w_state == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turbo_siso_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_turbo_siso_sched
// Purpose  : Self-checking bench for turbo_siso_sched with BLOCK_LEN=4,
//            STATES=4 (L=6). A procedural model walks the iteration /
//            half / sweep / step structure of a block and predicts every
//            output on every cycle, including stalls from siso_ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turbo_siso_sched;

    localparam int BL = 4;
    localparam int ST = 4;
    localparam int L  = BL + $clog2(ST);
    localparam int AW = $clog2(L);
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [IW-1:0] n_iter;
    logic          early_stop;
    logic          siso_ready;
    logic          siso_vld;
    logic [AW-1:0] siso_addr;
    logic          siso_dir;
    logic          siso_half;
    logic          siso_init;
    logic          siso_llr_en;
    logic [IW-1:0] iter_cnt;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    turbo_siso_sched #(
        .BLOCK_LEN (BL),
        .STATES    (ST),
        .ITER_W    (IW)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .n_iter      (n_iter),
        .early_stop  (early_stop),
        .siso_ready  (siso_ready),
        .siso_vld    (siso_vld),
        .siso_addr   (siso_addr),
        .siso_dir    (siso_dir),
        .siso_half   (siso_half),
        .siso_init   (siso_init),
        .siso_llr_en (siso_llr_en),
        .iter_cnt    (iter_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs all outputs as {addr, iter, 9'b0, vld, dir, half, init, llr, busy, done}.
    task automatic expect_outs(input string tag, input bit vld, input int addr, input bit dir,
                               input bit half, input bit init, input bit llr,
                               input bit e_busy, input bit e_done, input int iter);
        logic [31:0] g;
        logic [31:0] e;
        g = {8'(siso_addr), 8'(iter_cnt), 9'd0, siso_vld, siso_dir, siso_half,
             siso_init, siso_llr_en, busy, done};
        e = {8'(addr), 8'(iter), 9'd0, vld, dir, half, init, llr, e_busy, e_done};
        check(tag, g, e);
    endtask

    // mode: 0 = ready always 1, 1 = random ready, 2 = two stalls at FWD addr 3.
    // abort_cyc > 0: pulse reset on that cycle (counted from first FWD cycle).
    task automatic run_block(input int n, input int es_iter, input int mode, input int abort_cyc);
        int ne;
        int stop_it;
        int cyc;
        int stalls;
        int a;
        int tries;
        bit d;
        bit rdy;
        ne      = (n == 0) ? 1 : n;
        stop_it = (es_iter > 0 && es_iter < ne) ? es_iter : ne;
        stalls  = 0;
        start   = 1'b1;
        n_iter  = IW'(n);
        tick();
        start   = 1'b0;
        n_iter  = IW'($urandom);
        cyc     = 1;
        for (int it = 1; it <= stop_it; it++) begin
            for (int h = 0; h < 2; h++) begin
                for (int s = 0; s < 2 * L; s++) begin
                    d     = (s >= L);
                    a     = d ? (2 * L - 1 - s) : s;
                    tries = 0;
                    do begin
                        if (cyc == abort_cyc) begin
                            start   = 1'b0;
                            reset_n = 1'b0;
                            tick();
                            reset_n = 1'b1;
                            expect_outs("abort_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
                            return;
                        end
                        expect_outs("step", 1, a, d, h[0], (s == 0) || (s == L),
                                    d && (a < BL), 1, 0, it - 1);
                        case (mode)
                            0:       rdy = 1'b1;
                            1:       rdy = ($urandom % 4) != 0;
                            default: rdy = !(it == 1 && h == 0 && !d && a == 3 && tries < 2);
                        endcase
                        siso_ready = rdy;
                        start      = $urandom % 2;
                        early_stop = $urandom % 2;
                        tick();
                        cyc++;
                        tries++;
                        if (!rdy) stalls++;
                    end while (!rdy);
                end
                expect_outs("half_end", 0, 0, 0, h[0], 0, 0, 1, 0, it - 1);
                siso_ready = $urandom % 2;
                start      = $urandom % 2;
                early_stop = (h == 1) ? (it == es_iter) : ($urandom % 2);
                tick();
                cyc++;
            end
        end
        start      = 1'b0;
        early_stop = 1'b0;
        expect_outs("done", 0, 0, 0, 0, 0, 0, 1, 1, stop_it);
        check("done_cycle", cyc, stop_it * 2 * (2 * L + 1) + 1 + stalls);
        tick();
        expect_outs("idle_after", 0, 0, 0, 0, 0, 0, 0, 0, stop_it);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        n_iter     = '0;
        early_stop = 1'b0;
        siso_ready = 1'b0;
        repeat (3) tick();
        expect_outs("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        expect_outs("idle_no_start", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        run_block(1, 0, 0, 0);
        run_block(1, 0, 2, 0);
        run_block(0, 0, 0, 0);
        run_block(3, 0, 1, 0);
        run_block(5, 2, 1, 0);

        // Reset in the backward sweep of iteration 1, then a normal block.
        run_block(2, 0, 0, 9);
        tick();
        expect_outs("post_abort_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_block(2, 0, 1, 0);

        for (int k = 0; k < 4; k++) begin
            run_block(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
